// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: MEM-stage results/control in, register-file write port and status out.
// Optional MEM_WB_RETIRE_COUNT_EN adds the o_retired counter signal.
interface mem_wb_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]     i_dataread;
    logic [DATA_WIDTH-1:0]     i_aluresult;
    logic [DATA_WIDTH-1:0]     i_pcplus8;
    logic [REG_ADDR_WIDTH-1:0] i_rd;
    logic                      i_regwrite;
    logic [1:0]                i_wbsel;
    logic [1:0]                i_size;
    logic                      i_unsigned;
    logic                      i_valid;
    logic                      i_stall;
    logic                      i_flush;
    logic [DATA_WIDTH-1:0]     o_wbdata;
    logic [REG_ADDR_WIDTH-1:0] o_rd;
    logic                      o_regwrite;
    logic                      o_valid;
    logic                      o_misalign;
`ifdef MEM_WB_RETIRE_COUNT_EN
    logic [31:0]               o_retired;
`endif

    modport master (
        output i_dataread, i_aluresult, i_pcplus8, i_rd, i_regwrite, i_wbsel,
               i_size, i_unsigned, i_valid, i_stall, i_flush,
`ifdef MEM_WB_RETIRE_COUNT_EN
        input  o_retired,
`endif
        input  o_wbdata, o_rd, o_regwrite, o_valid, o_misalign
    );

    modport slave (
        input  i_dataread, i_aluresult, i_pcplus8, i_rd, i_regwrite, i_wbsel,
               i_size, i_unsigned, i_valid, i_stall, i_flush,
`ifdef MEM_WB_RETIRE_COUNT_EN
        output o_retired,
`endif
        output o_wbdata, o_rd, o_regwrite, o_valid, o_misalign
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load lane extraction, misalignment detection and writeback select.
// Latency 1 cycle; stall holds, flush inserts a bubble. Optional MEM_WB_RETIRE_COUNT_EN adds o_retired.
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic           i_clock,
    input  logic           i_reset,
    mem_wb_stage_if.slave  bus
);
    logic [DATA_WIDTH-1:0]     wbdata_q, wbdata_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      regwrite_q, regwrite_d;
    logic                      valid_q, valid_d;
    logic                      misalign_q, misalign_d;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  is_load;
    logic                  misaligned;
    logic                  sext;

    always_comb begin
        ld_byte  = bus.i_dataread[7:0];
        ld_half  = bus.i_dataread[15:0];
        load_val = bus.i_dataread;
        sext     = ~bus.i_unsigned;

        case (bus.i_aluresult[1:0])
            2'd0:    ld_byte = bus.i_dataread[7:0];
            2'd1:    ld_byte = bus.i_dataread[15:8];
            2'd2:    ld_byte = bus.i_dataread[23:16];
            default: ld_byte = bus.i_dataread[31:24];
        endcase
        ld_half = bus.i_aluresult[1] ? bus.i_dataread[31:16] : bus.i_dataread[15:0];

        case (bus.i_size)
            2'b00:   load_val = {{(DATA_WIDTH-8){sext & ld_byte[7]}}, ld_byte};
            2'b01:   load_val = {{(DATA_WIDTH-16){sext & ld_half[15]}}, ld_half};
            default: load_val = bus.i_dataread;
        endcase
    end

    // Reserved size 11 behaves as a word access, so it has the word alignment rule.
    always_comb begin
        is_load    = bus.i_valid && (bus.i_wbsel == 2'b01);
        misaligned = 1'b0;
        if (is_load) begin
            case (bus.i_size)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = bus.i_aluresult[0];
                default: misaligned = |bus.i_aluresult[1:0];
            endcase
        end
    end

    always_comb begin
        rd_d       = bus.i_rd;
        valid_d    = bus.i_valid;
        misalign_d = misalign_q | misaligned;
        regwrite_d = bus.i_regwrite & bus.i_valid & (bus.i_rd != '0) & ~misaligned;
        case (bus.i_wbsel)
            2'b01:   wbdata_d = load_val;
            2'b10:   wbdata_d = bus.i_pcplus8;
            default: wbdata_d = bus.i_aluresult;
        endcase
        if (misaligned) begin
            wbdata_d = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wbdata_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (bus.i_flush) begin
            // Sticky misalign survives a bubble; only reset clears it.
            wbdata_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (!bus.i_stall) begin
            wbdata_q   <= wbdata_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.o_wbdata   = wbdata_q;
    assign bus.o_rd       = rd_q;
    assign bus.o_regwrite = regwrite_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_misalign = misalign_q;

`ifdef MEM_WB_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (bus.i_valid && !misaligned) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            retired_q <= '0;
        end else if (!bus.i_flush && !bus.i_stall) begin
            retired_q <= retired_d;
        end
    end

    assign bus.o_retired = retired_q;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: stimulus pushes expected outputs, a monitor pops and compares.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] wbdata;
        logic [4:0]  rd;
        logic        regwrite;
        logic        valid;
        logic        misalign;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;
    bit   done     = 1'b0;

    task automatic drive(
        input logic        r,
        input logic        valid,
        input logic        regwrite,
        input logic [4:0]  rd,
        input logic [1:0]  wbsel,
        input logic [1:0]  size,
        input logic        uns,
        input logic [31:0] dataread,
        input logic [31:0] alu,
        input logic [31:0] pc8,
        input logic        stall,
        input logic        flush,
        input logic [31:0] e_wbdata,
        input logic [4:0]  e_rd,
        input logic        e_regwrite,
        input logic        e_valid,
        input logic        e_mis
    );
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.i_valid     = valid;
        bus.i_regwrite  = regwrite;
        bus.i_rd        = rd;
        bus.i_wbsel     = wbsel;
        bus.i_size      = size;
        bus.i_unsigned  = uns;
        bus.i_dataread  = dataread;
        bus.i_aluresult = alu;
        bus.i_pcplus8   = pc8;
        bus.i_stall     = stall;
        bus.i_flush     = flush;
        e.id       = vec_id;
        e.wbdata   = e_wbdata;
        e.rd       = e_rd;
        e.regwrite = e_regwrite;
        e.valid    = e_valid;
        e.misalign = e_mis;
        sb.push_back(e);
        vec_id++;
    endtask

    task automatic chk32(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one registered result becomes visible after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk32($sformatf("vec%0d", e.id),
                      {24'd0, bus.o_wbdata, bus.o_rd, bus.o_regwrite, bus.o_valid, bus.o_misalign},
                      {24'd0, e.wbdata, e.rd, e.regwrite, e.valid, e.misalign});
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_regwrite  = 1'b0;
        bus.i_rd        = '0;
        bus.i_wbsel     = '0;
        bus.i_size      = '0;
        bus.i_unsigned  = 1'b0;
        bus.i_dataread  = '0;
        bus.i_aluresult = '0;
        bus.i_pcplus8   = '0;
        bus.i_stall     = 1'b0;
        bus.i_flush     = 1'b0;

        // Reset with random inputs, then an idle slot.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 32'h0, 5'd0, 0, 0, 0);
        end
        drive(0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 5'd0, 0, 0, 0);

        // Byte loads, signed lanes 0..3 then unsigned lanes 2,3.
        drive(0, 1, 1, 5'd8, 2'b01, 2'b00, 0, 32'h80FF7F01, 32'h100, 32'h0, 0, 0, 32'h00000001, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b00, 0, 32'h80FF7F01, 32'h101, 32'h0, 0, 0, 32'h0000007F, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b00, 0, 32'h80FF7F01, 32'h102, 32'h0, 0, 0, 32'hFFFFFFFF, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b00, 0, 32'h80FF7F01, 32'h103, 32'h0, 0, 0, 32'hFFFFFF80, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b00, 1, 32'h80FF7F01, 32'h102, 32'h0, 0, 0, 32'h000000FF, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b00, 1, 32'h80FF7F01, 32'h103, 32'h0, 0, 0, 32'h00000080, 5'd8, 1, 1, 0);

        // Halfword loads, signed and unsigned, plus an aligned word load.
        drive(0, 1, 1, 5'd8, 2'b01, 2'b01, 0, 32'h8001ABCD, 32'h104, 32'h0, 0, 0, 32'hFFFFABCD, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b01, 0, 32'h8001ABCD, 32'h106, 32'h0, 0, 0, 32'hFFFF8001, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b01, 1, 32'h8001ABCD, 32'h104, 32'h0, 0, 0, 32'h0000ABCD, 5'd8, 1, 1, 0);
        drive(0, 1, 1, 5'd8, 2'b01, 2'b10, 0, 32'h8001ABCD, 32'h108, 32'h0, 0, 0, 32'h8001ABCD, 5'd8, 1, 1, 0);

        // Writeback select, reserved select, $zero destination, invalid slot.
        drive(0, 1, 1, 5'd3,  2'b00, 2'b00, 0, 32'hFFFFFFFF, 32'h12345678, 32'h00400010, 0, 0, 32'h12345678, 5'd3, 1, 1, 0);
        drive(0, 1, 1, 5'd31, 2'b10, 2'b00, 0, 32'hFFFFFFFF, 32'h12345678, 32'h00400010, 0, 0, 32'h00400010, 5'd31, 1, 1, 0);
        drive(0, 1, 1, 5'd6,  2'b11, 2'b00, 0, 32'hFFFFFFFF, 32'h0BADF00D, 32'h00400010, 0, 0, 32'h0BADF00D, 5'd6, 1, 1, 0);
        drive(0, 1, 1, 5'd0,  2'b00, 2'b00, 0, 32'hFFFFFFFF, 32'h12345678, 32'h00400010, 0, 0, 32'h12345678, 5'd0, 0, 1, 0);
        drive(0, 1, 1, 5'd0,  2'b10, 2'b00, 0, 32'hFFFFFFFF, 32'h12345678, 32'h00400010, 0, 0, 32'h00400010, 5'd0, 0, 1, 0);
        drive(0, 0, 1, 5'd5,  2'b00, 2'b00, 0, 32'hFFFFFFFF, 32'h0000DEAD, 32'h00400010, 0, 0, 32'h0000DEAD, 5'd5, 0, 0, 0);
        // Misaligned-looking word address on an invalid slot must not raise the flag.
        drive(0, 0, 1, 5'd5,  2'b01, 2'b10, 0, 32'h11111111, 32'h00000103, 32'h0, 0, 0, 32'h11111111, 5'd5, 0, 0, 0);

        // Capture 0xA5, stall three cycles with changing inputs, then stall+flush.
        drive(0, 1, 1, 5'd4, 2'b00, 2'b00, 0, 32'h0, 32'h000000A5, 32'h0, 0, 0, 32'h000000A5, 5'd4, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 5'd7, 2'b10, 2'b00, 0, $urandom, $urandom, $urandom, 1, 0, 32'h000000A5, 5'd4, 1, 1, 0);
        end
        drive(0, 1, 1, 5'd7, 2'b00, 2'b00, 0, 32'h0, 32'h00000077, 32'h0, 1, 1, 32'h0, 5'd0, 0, 0, 0);
        drive(0, 1, 1, 5'd9, 2'b00, 2'b00, 0, 32'h0, 32'h00000099, 32'h0, 0, 0, 32'h00000099, 5'd9, 1, 1, 0);
        // Reset mid-operation overrides stall and flush and discards the instruction.
        drive(1, 1, 1, 5'd9, 2'b00, 2'b00, 0, 32'h0, 32'h00000055, 32'h0, 1, 1, 32'h0, 5'd0, 0, 0, 0);

        // Misaligned halfword and word loads set the sticky flag.
        drive(0, 1, 1, 5'd9, 2'b01, 2'b10, 0, 32'hCAFEBABE, 32'h00000103, 32'h0, 0, 0, 32'h0, 5'd9, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 5'd0, 0, 0, 1);
        end
        drive(0, 1, 1, 5'd2, 2'b00, 2'b00, 0, 32'h0, 32'h00000042, 32'h0, 0, 1, 32'h0, 5'd0, 0, 0, 1);
        drive(1, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 5'd0, 0, 0, 0);
        drive(0, 1, 1, 5'd9, 2'b01, 2'b01, 0, 32'hCAFEBABE, 32'h00000105, 32'h0, 0, 0, 32'h0, 5'd9, 0, 1, 1);
        drive(1, 0, 0, 5'd0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 5'd0, 0, 0, 0);

`ifdef MEM_WB_RETIRE_COUNT_EN
        // Counter: 5 valid captures, 2 stalls, 1 flush, 1 misaligned load.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 1, 5'd1, 2'b00, 2'b00, 0, 32'h0, 32'(i), 32'h0, 0, 0, 32'(i), 5'd1, 1, 1, 0);
        end
        drive(0, 1, 1, 5'd1, 2'b00, 2'b00, 0, 32'h0, 32'h7, 32'h0, 1, 0, 32'h4, 5'd1, 1, 1, 0);
        drive(0, 1, 1, 5'd1, 2'b00, 2'b00, 0, 32'h0, 32'h7, 32'h0, 1, 0, 32'h4, 5'd1, 1, 1, 0);
        drive(0, 1, 1, 5'd1, 2'b00, 2'b00, 0, 32'h0, 32'h7, 32'h0, 0, 1, 32'h0, 5'd0, 0, 0, 0);
        drive(0, 1, 1, 5'd1, 2'b01, 2'b10, 0, 32'h0, 32'h2, 32'h0, 0, 0, 32'h0, 5'd1, 0, 1, 1);
        @(negedge clk);
        chk32("retired_count", {32'd0, bus.o_retired}, 64'd5);
        force dut.retired_q = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.retired_q;
        drive(0, 1, 1, 5'd1, 2'b00, 2'b00, 0, 32'h0, 32'h3, 32'h0, 0, 0, 32'h3, 5'd1, 1, 1, 1);
        @(negedge clk);
        chk32("retired_wrap", {32'd0, bus.o_retired}, 64'd0);
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
